ctrl_fsm: RTL and testbench

- Multi-cycle control unit that sequences the CPU datapath through fetch, decode, execute, memory and writeback phases.
- Drives the program counter's enable and its 2-bit control code: 01 = increment, 11 = load {8'h00, offset_addr}, other codes = hold.
- Also drives the instruction-register load, memory read/write strobes, ALU function select and register-file write enable.
- Sits between the IR/flag register and every datapath enable.

---
 rtl/cpu_defs.sv | 55 +++++
 rtl/ctrl_decode.sv | 118 +++++++++++
 rtl/ctrl_fsm.sv | 114 +++++++++++
 tb/tb_ctrl_fsm.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, state
// encodings, PC control codes and ALU function codes.
package cpu_defs;

   localparam int OP_WIDTH  = 5;
   localparam int ALU_WIDTH = 3;

   // Controller states; the encoding is visible on debug probes, keep it fixed.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH1 = 3'd1,
      S_FETCH2 = 3'd2,
      S_DECODE = 3'd3,
      S_EXEC   = 3'd4,
      S_MEM    = 3'd5,
      S_WB     = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   // Opcodes as found in IR[15:11].
   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_AND  = 5'b00011;
   localparam logic [4:0] OP_MOV  = 5'b00100;
   localparam logic [4:0] OP_LDA  = 5'b00101;
   localparam logic [4:0] OP_STA  = 5'b00110;
   localparam logic [4:0] OP_JMP  = 5'b00111;
   localparam logic [4:0] OP_JZ   = 5'b01000;
   localparam logic [4:0] OP_JC   = 5'b01001;
   localparam logic [4:0] OP_HALT = 5'b11111;

   // PC control codes; 10 is unused and behaves as hold in the PC.
   localparam logic [1:0] PC_HOLD = 2'b00;
   localparam logic [1:0] PC_INC  = 2'b01;
   localparam logic [1:0] PC_LOAD = 2'b11;

   // ALU function select codes.
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_PASS = 3'b011;

   // True when the opcode belongs to the implemented instruction set.
   function automatic logic op_defined(input logic [4:0] op);
      logic ok;
      case (op)
         OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_MOV, OP_LDA,
         OP_STA, OP_JMP, OP_JZ, OP_JC, OP_HALT: ok = 1'b1;
         default:                               ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Output decoder for the control FSM: maps the current state, the latched
// opcode and the ALU flags onto every datapath strobe. Purely combinational.
module ctrl_decode
   import cpu_defs::*;
#(
   parameter int OP_W  = OP_WIDTH,
   parameter int ALU_W = ALU_WIDTH
) (
   input  logic [2:0]       state,
   input  logic [OP_W-1:0]  op_q,
   input  logic [OP_W-1:0]  ir_opcode,
   input  logic             zero_flag,
   input  logic             carry_flag,
   output logic             en_ir,
   output logic             en_pc,
   output logic [1:0]       pc_ctrl,
   output logic             en_ram_out,
   output logic             en_ram_in,
   output logic             en_alu,
   output logic [ALU_W-1:0] alu_func,
   output logic             en_reg,
   output logic             busy,
   output logic             halted,
   output logic             illegal_op
);

   // Strobe decode: every output defaults to inactive, each state raises its own.
   always_comb begin
      en_ir      = 1'b0;
      en_pc      = 1'b0;
      pc_ctrl    = PC_HOLD;
      en_ram_out = 1'b0;
      en_ram_in  = 1'b0;
      en_alu     = 1'b0;
      alu_func   = {ALU_W{1'b0}};
      en_reg     = 1'b0;
      illegal_op = 1'b0;
      busy       = (state != S_IDLE) && (state != S_HALT);
      halted     = (state == S_HALT);
      case (state)
         S_FETCH1: begin
            en_ram_out = 1'b1;
            en_ir      = 1'b1;
         end
         S_FETCH2: begin
            en_pc   = 1'b1;
            pc_ctrl = PC_INC;
         end
         S_DECODE: begin
            // The IR is live here; op_q only captures it at the end of DECODE.
            if (!op_defined(ir_opcode)) begin
               illegal_op = 1'b1;
            end else begin
               illegal_op = 1'b0;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_ADD: begin
                  en_alu   = 1'b1;
                  alu_func = ALU_ADD;
               end
               OP_SUB: begin
                  en_alu   = 1'b1;
                  alu_func = ALU_SUB;
               end
               OP_AND: begin
                  en_alu   = 1'b1;
                  alu_func = ALU_AND;
               end
               OP_MOV: begin
                  en_alu   = 1'b1;
                  alu_func = ALU_PASS;
               end
               OP_JMP: begin
                  en_pc   = 1'b1;
                  pc_ctrl = PC_LOAD;
               end
               OP_JZ: begin
                  if (zero_flag) begin
                     en_pc   = 1'b1;
                     pc_ctrl = PC_LOAD;
                  end else begin
                     en_pc   = 1'b0;
                     pc_ctrl = PC_HOLD;
                  end
               end
               OP_JC: begin
                  if (carry_flag) begin
                     en_pc   = 1'b1;
                     pc_ctrl = PC_LOAD;
                  end else begin
                     en_pc   = 1'b0;
                     pc_ctrl = PC_HOLD;
                  end
               end
               default: begin
                  en_alu = 1'b0;
               end
            endcase
         end
         S_MEM: begin
            case (op_q)
               OP_LDA:  en_ram_out = 1'b1;
               OP_STA:  en_ram_in  = 1'b1;
               default: en_ram_out = 1'b0;
            endcase
         end
         S_WB: begin
            en_reg = 1'b1;
         end
         default: begin
            en_ir = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle CPU control unit: sequences fetch, decode, execute, memory and
// writeback. Holds the state register and latched opcode; strobes come from
// ctrl_decode so they follow the state asynchronously, including on reset.
module ctrl_fsm
   import cpu_defs::*;
#(
   parameter int OP_W  = OP_WIDTH,
   parameter int ALU_W = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [OP_W-1:0]  ir_opcode,
   input  logic             zero_flag,
   input  logic             carry_flag,
   output logic             en_ir,
   output logic             en_pc,
   output logic [1:0]       pc_ctrl,
   output logic             en_ram_out,
   output logic             en_ram_in,
   output logic             en_alu,
   output logic [ALU_W-1:0] alu_func,
   output logic             en_reg,
   output logic             busy,
   output logic             halted,
   output logic             illegal_op
);

   state_t          state_q;
   state_t          next_state;
   state_t          boundary;
   logic [OP_W-1:0] op_q;

   // State register and opcode latch; reset drops straight back to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= {OP_W{1'b0}};
      end else begin
         state_q <= next_state;
         if (state_q == S_DECODE) begin
            op_q <= ir_opcode;
         end
      end
   end

   // Next-state logic; instructions always run to completion before en is honoured.
   always_comb begin
      boundary   = en ? S_FETCH1 : S_IDLE;
      next_state = state_q;
      case (state_q)
         S_IDLE: begin
            if (en) begin
               next_state = S_FETCH1;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_FETCH1: next_state = S_FETCH2;
         S_FETCH2: next_state = S_DECODE;
         S_DECODE: begin
            case (ir_opcode)
               OP_NOP:  next_state = boundary;
               OP_HALT: next_state = S_HALT;
               OP_ADD, OP_SUB, OP_AND, OP_MOV,
               OP_JMP, OP_JZ, OP_JC:
                        next_state = S_EXEC;
               OP_LDA, OP_STA:
                        next_state = S_MEM;
               default: next_state = boundary;
            endcase
         end
         S_EXEC: begin
            case (op_q)
               OP_ADD, OP_SUB, OP_AND, OP_MOV:
                        next_state = S_WB;
               default: next_state = boundary;
            endcase
         end
         S_MEM: begin
            case (op_q)
               OP_LDA:  next_state = S_WB;
               default: next_state = boundary;
            endcase
         end
         S_WB:    next_state = boundary;
         S_HALT:  next_state = S_HALT;
         default: next_state = S_IDLE;
      endcase
   end

   ctrl_decode #(
      .OP_W  (OP_W),
      .ALU_W (ALU_W)
   ) u_decode (
      .state      (state_q),
      .op_q       (op_q),
      .ir_opcode  (ir_opcode),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
      .en_ir      (en_ir),
      .en_pc      (en_pc),
      .pc_ctrl    (pc_ctrl),
      .en_ram_out (en_ram_out),
      .en_ram_in  (en_ram_in),
      .en_alu     (en_alu),
      .alu_func   (alu_func),
      .en_reg     (en_reg),
      .busy       (busy),
      .halted     (halted),
      .illegal_op (illegal_op)
   );

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: a per-cycle expected record is queued for
// each instruction issued and popped/compared every cycle.
module tb_ctrl_fsm;

   localparam logic [4:0] NOP  = 5'b00000;
   localparam logic [4:0] ADD  = 5'b00001;
   localparam logic [4:0] SUB  = 5'b00010;
   localparam logic [4:0] ANDO = 5'b00011;
   localparam logic [4:0] MOV  = 5'b00100;
   localparam logic [4:0] LDA  = 5'b00101;
   localparam logic [4:0] STA  = 5'b00110;
   localparam logic [4:0] JMP  = 5'b00111;
   localparam logic [4:0] JZ   = 5'b01000;
   localparam logic [4:0] JC   = 5'b01001;
   localparam logic [4:0] HLT  = 5'b11111;
   localparam logic [4:0] BAD  = 5'b01010;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [4:0] ir_opcode;
   logic       zero_flag;
   logic       carry_flag;
   logic       en_ir, en_pc, en_ram_out, en_ram_in, en_alu, en_reg;
   logic       busy, halted, illegal_op;
   logic [1:0] pc_ctrl;
   logic [2:0] alu_func;

   typedef struct packed {
      logic [2:0] st;
      logic       ir;
      logic       pc;
      logic [1:0] pcc;
      logic       ro;
      logic       ri;
      logic       alu;
      logic [2:0] af;
      logic       regw;
      logic       busy;
      logic       halted;
      logic       ill;
   } obs_t;

   obs_t sb_q[$];
   obs_t seq[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ctrl_fsm dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .ir_opcode  (ir_opcode),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
      .en_ir      (en_ir),
      .en_pc      (en_pc),
      .pc_ctrl    (pc_ctrl),
      .en_ram_out (en_ram_out),
      .en_ram_in  (en_ram_in),
      .en_alu     (en_alu),
      .alu_func   (alu_func),
      .en_reg     (en_reg),
      .busy       (busy),
      .halted     (halted),
      .illegal_op (illegal_op)
   );

   function automatic obs_t base(input logic [2:0] st);
      obs_t o;
      o        = '0;
      o.st     = st;
      o.busy   = (st != 3'd0) && (st != 3'd7);
      o.halted = (st == 3'd7);
      return o;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.st     = dut.state_q;
      o.ir     = en_ir;
      o.pc     = en_pc;
      o.pcc    = pc_ctrl;
      o.ro     = en_ram_out;
      o.ri     = en_ram_in;
      o.alu    = en_alu;
      o.af     = alu_func;
      o.regw   = en_reg;
      o.busy   = busy;
      o.halted = halted;
      o.ill    = illegal_op;
      return o;
   endfunction

   // Reference model: expected per-cycle outputs of one instruction from FETCH1.
   function automatic void build(input logic [4:0] op, input logic z, input logic c);
      obs_t o;
      seq.delete();
      o = base(3'd1); o.ir = 1'b1; o.ro = 1'b1; seq.push_back(o);
      o = base(3'd2); o.pc = 1'b1; o.pcc = 2'b01; seq.push_back(o);
      o = base(3'd3);
      o.ill = !(op inside {NOP, ADD, SUB, ANDO, MOV, LDA, STA, JMP, JZ, JC, HLT});
      seq.push_back(o);
      case (op)
         ADD, SUB, ANDO, MOV: begin
            o = base(3'd4); o.alu = 1'b1;
            o.af = (op == ADD) ? 3'b000 : (op == SUB) ? 3'b001 : (op == ANDO) ? 3'b010 : 3'b011;
            seq.push_back(o);
            o = base(3'd6); o.regw = 1'b1; seq.push_back(o);
         end
         JMP: begin
            o = base(3'd4); o.pc = 1'b1; o.pcc = 2'b11; seq.push_back(o);
         end
         JZ, JC: begin
            o = base(3'd4);
            if ((op == JZ) ? z : c) begin
               o.pc = 1'b1; o.pcc = 2'b11;
            end
            seq.push_back(o);
         end
         LDA: begin
            o = base(3'd5); o.ro = 1'b1; seq.push_back(o);
            o = base(3'd6); o.regw = 1'b1; seq.push_back(o);
         end
         STA: begin
            o = base(3'd5); o.ri = 1'b1; seq.push_back(o);
         end
         default: begin
         end
      endcase
   endfunction

   task automatic check_obs(input string tag, input obs_t exp);
      obs_t act;
      act = observe();
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, act, exp);
      end
   endtask

   // One clock: drive inputs just after the edge, then compare against the queue head.
   task automatic cycle(input logic en_v, input logic [4:0] op, input logic z,
                        input logic c, input string tag);
      obs_t exp;
      @(posedge clk);
      #1;
      en = en_v; ir_opcode = op; zero_flag = z; carry_flag = c;
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         exp = sb_q.pop_front();
         check_obs(tag, exp);
      end
   endtask

   task automatic idle_cycle(input logic en_v, input string tag);
      sb_q.push_back(base(3'd0));
      cycle(en_v, NOP, 1'b0, 1'b0, tag);
   endtask

   // Issue one instruction; en drops from cycle index drop_at, ncyc>0 truncates the run.
   task automatic run_instr(input logic [4:0] op, input logic z, input logic c,
                            input int drop_at, input int ncyc, input string tag);
      int n;
      build(op, z, c);
      n = (ncyc == 0) ? seq.size() : ncyc;
      foreach (seq[i]) sb_q.push_back(seq[i]);
      for (int i = 0; i < n; i++) begin
         cycle((i < drop_at) ? 1'b1 : 1'b0, op, z, c, tag);
      end
      sb_q.delete();
   endtask

   // Mutual-exclusion invariants checked on every cycle out of reset.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         checks++;
         assert (!(en_ram_in && en_ram_out)) else begin
            errors++;
            $error("FAIL ram_excl observed=%b%b expected=not_both", en_ram_in, en_ram_out);
         end
         checks++;
         assert (!en_pc || pc_ctrl == 2'b01 || pc_ctrl == 2'b11) else begin
            errors++;
            $error("FAIL pc_code observed=%b expected=01_or_11", pc_ctrl);
         end
      end
   end

   initial begin
      rst = 1'b0; en = 1'b0; ir_opcode = NOP; zero_flag = 1'b0; carry_flag = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check_obs("reset", base(3'd0));
      checks++;
      assert (dut.op_q === 5'd0) else begin
         errors++;
         $error("FAIL reset_op_q observed=%h expected=00", dut.op_q);
      end
      @(negedge clk) rst = 1'b1;

      idle_cycle(1'b1, "idle_start");
      run_instr(NOP,  1'b0, 1'b0, 99, 0, "nop");
      run_instr(ADD,  1'b0, 1'b0, 99, 0, "add");
      run_instr(JZ,   1'b1, 1'b0, 99, 0, "jz_taken");
      run_instr(JZ,   1'b0, 1'b1, 99, 0, "jz_not");
      run_instr(JC,   1'b0, 1'b1, 99, 0, "jc_taken");
      run_instr(JC,   1'b1, 1'b0, 99, 0, "jc_not");
      run_instr(JMP,  1'b0, 1'b0, 99, 0, "jmp");
      run_instr(LDA,  1'b0, 1'b0, 99, 0, "lda");
      run_instr(STA,  1'b0, 1'b0, 99, 0, "sta");
      run_instr(ANDO, 1'b0, 1'b0, 99, 0, "and");
      run_instr(MOV,  1'b0, 1'b0, 99, 0, "mov");
      run_instr(BAD,  1'b0, 1'b0, 99, 0, "illegal");
      run_instr(SUB,  1'b0, 1'b0, 1,  0, "sub_stop");
      idle_cycle(1'b0, "idle_stopped");
      idle_cycle(1'b1, "idle_resume");
      run_instr(NOP,  1'b0, 1'b0, 99, 0, "resume");
      run_instr(HLT,  1'b0, 1'b0, 99, 0, "halt_decode");
      for (int i = 0; i < 20; i++) begin
         sb_q.push_back(base(3'd7));
         cycle(1'($urandom_range(0, 1)), NOP, 1'b0, 1'b0, "halt_hold");
      end

      @(negedge clk);
      en  = 1'b0;
      rst = 1'b0;
      #1;
      check_obs("halt_rst", base(3'd0));
      @(negedge clk) rst = 1'b1;

      idle_cycle(1'b1, "idle_after_halt");
      run_instr(ADD, 1'b0, 1'b0, 99, 4, "add_to_exec");
      rst = 1'b0;
      #1;
      check_obs("rst_in_exec", base(3'd0));
      checks++;
      assert (dut.op_q === 5'd0) else begin
         errors++;
         $error("FAIL rst_op_q observed=%h expected=00", dut.op_q);
      end
      en = 1'b0;
      @(negedge clk) rst = 1'b1;
      idle_cycle(1'b0, "post_rst_idle");

      checks++;
      assert (sb_q.size() == 0) else begin
         errors++;
         $error("FAIL queue_drain observed=%0d expected=0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
